// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 register file between NREQ
// writeback sources (ALU, load unit, mul/div, ...). At most one request is
// granted per cycle. The granted write is registered and driven straight
// into the register file one cycle later.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   [NREQ]     pending write from requester i
//   req_addr    [NREQ*AW]  destination register, slice [i*AW +: AW]
//   req_data    [NREQ*DW]  write data, slice [i*DW +: DW]
//   req_ready   [NREQ]     combinational one-hot grant (zero when idle)
//   wb_stall    suppresses any grant this cycle
//   reg_write   registered write enable (never set for r0)
//   write_reg   registered write address
//   write_data  registered write data
//   grant_cnt   16-bit count of accepted transfers, r0 writes included
//
// Build option:
//   WBARB_FIXED_PRIO_EN  when defined, lowest index always wins and the
//                        round-robin pointer is not built. Default is
//                        round-robin arbitration.

module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               wb_stall,
   output logic               reg_write,
   output logic [AW-1:0]      write_reg,
   output logic [DW-1:0]      write_data,
   output logic [15:0]        grant_cnt
);

   // Candidate set the lowest-index picker works on. In round-robin mode
   // this is the valid set restricted to indices at or after the pointer,
   // falling back to the full valid set when nothing lies at or after it;
   // that gives the circular search order rr_ptr, rr_ptr+1, ... mod NREQ.
   logic [NREQ-1:0] pick_vec;
   logic [NREQ-1:0] grant;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            xfer;

`ifdef WBARB_FIXED_PRIO_EN

   assign pick_vec = req_valid;

`else

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gnt_idx;
   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] upper_valid;

   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) begin
         upper[i] = (PW'(i) >= rr_ptr);
      end
      upper_valid = req_valid & upper;
      pick_vec    = (|upper_valid) ? upper_valid : req_valid;
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_idx = PW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

`endif

   // Lowest set bit of pick_vec wins; scanning downwards lets the last
   // hit (the lowest index) overwrite any earlier one.
   always_comb begin
      grant    = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
      end
   end

   // Ready is forced low during reset so nothing is accepted in the cycle
   // reset rises; the grant only ever covers valid requesters, so any
   // ready bit is a transfer.
   assign req_ready = (rst || wb_stall) ? '0 : grant;
   assign xfer      = |req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         grant_cnt  <= '0;
      end else begin
         // r0 writes are accepted and counted but never forwarded.
         reg_write <= xfer && (sel_addr != '0);
         if (xfer) begin
            write_reg  <= sel_addr;
            write_data <= sel_data;
            grant_cnt  <= grant_cnt + 16'd1;
         end
      end
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32x32 register file. It shares the file's single write port between `NREQ` writeback sources, for example the ALU, the load unit and a multi-cycle multiply/divide unit. Each source presents a valid/ready request. The block grants at most one request per cycle, round-robin, and drives a registered `reg_write` / `write_reg` / `write_data` triple straight into the register file.

## Interface
- `NREQ`, default 3: number of writeback requesters, 2..8.
- `AW`, default 5: register address width.
- `DW`, default 32: data width.

- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: bit i set means requester i holds a pending write.
- `req_addr`  in  NREQ*AW: destination register of requester i, in slice [i*AW +: AW].
- `req_data`  in  NREQ*DW: write data of requester i, in slice [i*DW +: DW].
- `req_ready`  out  NREQ: one-hot or zero; combinational grant for the current cycle.
- `wb_stall`  in  1: when high, no grant is issued this cycle.
- `reg_write`  out  1: registered write enable to the register file.
- `write_reg`  out  AW: registered write address.
- `write_data`  out  DW: registered write data.
- `grant_cnt`  out  16: count of accepted transfers, including r0 writes. Wraps 0xFFFF -> 0.

## Operation
- Handshake:
  - Transfer i occurs when `req_valid[i] & req_ready[i]` in a cycle.
  - A requester must hold `req_addr`/`req_data` stable and keep valid high until it sees ready.
  - Dropping valid before ready is allowed (request withdrawn). No side effects.
- Grant:
  - `req_ready = 0` whenever `rst` or `wb_stall` is high.
  - Otherwise the first valid requester at or after the round-robin pointer `rr_ptr` gets ready. Search order is `rr_ptr`, `rr_ptr+1`, ... mod NREQ.
  - Exactly one bit is set if any valid is set; all zero otherwise.
- Pointer:
  - After a transfer from i, `rr_ptr` becomes (i+1) mod NREQ.
  - With no transfer, `rr_ptr` holds its value.
  - Reset value is 0.
- Output stage:
  - On a transfer from i, the next edge loads `write_reg <= addr_i` and `write_data <= data_i`.
  - `reg_write <= (addr_i != 0)`. Writes to r0 are accepted (ready asserted, counted) but never forwarded.
  - With no transfer, `reg_write <= 0`. `write_reg` and `write_data` hold their previous values.
- `grant_cnt` increments by 1 per transfer.
- Only one state register set exists, no FIFO. Throughput is one write per cycle.

## Timing
- Reset values:
  - `reg_write`=0, `write_reg`=0, `write_data`=0, `grant_cnt`=0, `rr_ptr`=0.
  - `req_ready`=0 while `rst` is high.
- Assertion of `rst` clears all of these immediately, without waiting for a clock edge.
- Reset mid-operation:
  - A transfer accepted in the cycle `rst` rises is discarded.
  - A pending `reg_write` is cancelled.
- Latency:
  - A request granted in cycle t appears on `reg_write`/`write_reg`/`write_data` in cycle t+1.
  - The register file commits it at the edge ending t+1. It is readable from cycle t+2.
- `req_ready` is a combinational function of `req_valid`, `rr_ptr` and `wb_stall`. It does not depend on `req_addr` or `req_data`.
- `wb_stall` high in cycle t means no transfer in t and `reg_write`=0 in t+1. `rr_ptr` is unchanged.
- Simultaneous requests to the same address are serialized by the pointer. The later grant wins in the register file.
- A back-to-back single requester is granted every cycle, since the pointer wraps back to it when no other requester is valid.

## Configuration
- `WBARB_FIXED_PRIO_EN`:
  - Defined: grant uses fixed priority, lowest index wins. `rr_ptr` is not implemented; all other behaviour is unchanged.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset:
  - Stimulus: assert `rst` with `req_valid`=3'b111.
  - Required: `req_ready`=0, `reg_write`=0, `write_reg`=0, `write_data`=0 and `grant_cnt`=0 during reset.
  - Required: first grant after release goes to requester 0.
- Round-robin:
  - Stimulus: all three valid continuously for 6 cycles, with addresses 1/2/3 and data 0xA/0xB/0xC.
  - Required: grants 0,1,2,0,1,2 and `reg_write`=1 each cycle one cycle later, with `write_reg` 1,2,3,...
  - Required: `grant_cnt`=6.
- r0 drop:
  - Stimulus: only requester 1 valid, addr 0, data 0xDEADBEEF.
  - Required: `req_ready[1]`=1, `reg_write`=0 next cycle, `grant_cnt` increments.
  - Required: a subsequent read of r0 returns 0.
- Stall:
  - Stimulus: `wb_stall`=1 for 2 cycles with requester 2 valid.
  - Required: `req_ready`=0 and `reg_write`=0 on both following cycles.
  - Required: requester 2 is granted in the first cycle after the stall ends, with `rr_ptr` unchanged until then.
- Reset mid-write:
  - Stimulus: grant requester 0 (addr 5, data 0x1234), then assert `rst` in the next cycle.
  - Required: `reg_write` drops immediately and r5 stays 0.
- Fixed priority:
  - Stimulus: with `WBARB_FIXED_PRIO_EN` defined, requesters 0 and 2 continuously valid.
  - Required: requester 0 is granted every cycle and requester 2 is never granted.
